// File: rtl/axon_scheduler.sv
// Axon delay-ring scheduler: spikes are parked in a ring of timestep slots and
// one slot is drained into an axon vector per tick, handed downstream by valid/ready.
module axon_scheduler #(
  parameter int NUM_SLOTS = 16,
  parameter int NUM_AXONS = 8,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int AW = $clog2(NUM_AXONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spk_valid,
  output logic                 spk_ready,
  input  logic [AW-1:0]        spk_axon,
  input  logic [3:0]           spk_delay,
  input  logic                 tick,
  output logic [NUM_AXONS-1:0] out_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        cur_slot,
  output logic [7:0]           spike_count,
  output logic                 tick_overrun
);

  typedef enum logic [1:0] {IDLE, DRAIN, PRESENT} state_t;

  // Wide enough to hold cur_slot + spk_delay without overflow before the modulo.
  localparam int SUMW = ((SW > 4) ? SW : 4) + 1;

  state_t               state_q, state_d;
  logic [NUM_AXONS-1:0] slots_q [NUM_SLOTS];
  logic [NUM_AXONS-1:0] slots_d [NUM_SLOTS];
  logic [NUM_AXONS-1:0] out_vec_q, out_vec_d;
  logic                 out_valid_q, out_valid_d;
  logic [SW-1:0]        cur_slot_q, cur_slot_d;
  logic [7:0]           count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;

  logic                 accept;
  logic                 draining;
  logic                 drain_hit;
  logic                 handshake;
  logic [SUMW-1:0]      slot_sum;
  logic [SW-1:0]        tgt_slot;
  logic [NUM_AXONS-1:0] axon_bit;

  assign spk_ready = rst;
  assign accept    = spk_valid && spk_ready;
  assign draining  = (state_q == DRAIN);
  assign handshake = out_valid_q && out_ready;
  assign slot_sum  = SUMW'(cur_slot_q) + SUMW'(spk_delay);
  assign tgt_slot  = slot_sum[SW-1:0];
  assign axon_bit  = NUM_AXONS'(1) << spk_axon;
  // A spike aimed at the slot being drained goes straight into out_vec.
  assign drain_hit = accept && draining && (tgt_slot == cur_slot_q);

  always_comb begin
    state_d     = state_q;
    slots_d     = slots_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
    cur_slot_d  = cur_slot_q;
    count_d     = count_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;

    if (accept && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end

    if (draining) begin
      out_vec_d           = slots_q[cur_slot_q] | (drain_hit ? axon_bit : '0);
      slots_d[cur_slot_q] = '0;
      cur_slot_d          = cur_slot_q + SW'(1);
      out_valid_d         = 1'b1;
    end

    if (accept && !drain_hit) begin
      slots_d[tgt_slot] = slots_d[tgt_slot] | axon_bit;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = PRESENT;
        if (tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      PRESENT: begin
        // With a pending tick, a fresh tick is dropped even when it coincides with the handshake.
        if (tick) begin
          if (pending_q)       overrun_d = 1'b1;
          else if (!handshake) pending_d = 1'b1;
        end
        if (handshake) begin
          out_valid_d = 1'b0;
          pending_d   = 1'b0;
          state_d     = (pending_q || tick) ? DRAIN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      cur_slot_q  <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slots_q     <= slots_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
      cur_slot_q  <= cur_slot_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_vec      = out_vec_q;
  assign out_valid    = out_valid_q;
  assign cur_slot     = cur_slot_q;
  assign spike_count  = count_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_axon_scheduler.sv
// Self-checking bench for axon_scheduler: a ring model predicts each drained
// axon vector, and a monitor compares it when the DUT hands out_vec downstream.
module tb_axon_scheduler;

   logic       clk;
   logic       rst;
   logic       spkValid;
   logic       spkReady;
   logic [2:0] spkAxon;
   logic [3:0] spkDelay;
   logic       tick;
   logic [7:0] outVec;
   logic       outValid;
   logic       outReady;
   logic [3:0] curSlot;
   logic [7:0] spikeCount;
   logic       tickOverrun;

   int assertCount = 0;
   int failCount   = 0;

   logic [7:0] modelRing [16];
   int         modelCur;
   int         modelCount;
   logic [7:0] expQueue [$];

   axon_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .spk_valid    (spkValid),
      .spk_ready    (spkReady),
      .spk_axon     (spkAxon),
      .spk_delay    (spkDelay),
      .tick         (tick),
      .out_vec      (outVec),
      .out_valid    (outValid),
      .out_ready    (outReady),
      .cur_slot     (curSlot),
      .spike_count  (spikeCount),
      .tick_overrun (tickOverrun)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance to just after the next rising edge so inputs change away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Clear the reference ring and scoreboard to mirror a reset
   task automatic clearModel();
      for (int i = 0; i < 16; i++) modelRing[i] = 8'h00;
      modelCur   = 0;
      modelCount = 0;
      expQueue.delete();
   endtask

   // Pulse reset low and check every output drops immediately
   task automatic applyReset();
      rst = 1'b0;
      #1;
      clearModel();
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_vec", outVec, 0);
      checkOutput("rst_cur_slot", curSlot, 0);
      checkOutput("rst_spike_count", spikeCount, 0);
      checkOutput("rst_overrun", tickOverrun, 0);
      checkOutput("rst_spk_ready", spkReady, 0);
      step();
      step();
      rst = 1'b1;
      #1;
      checkOutput("spk_ready_after_rst", spkReady, 1);
   endtask

   // Drive one spike for one cycle and record where it should land
   task automatic applyStimulus(input int axon, input int delay);
      int tgt;
      spkValid = 1'b1;
      spkAxon  = 3'(axon);
      spkDelay = 4'(delay);
      tgt = (modelCur + delay) % 16;
      modelRing[tgt][axon] = 1'b1;
      if (modelCount < 255) modelCount++;
      step();
      spkValid = 1'b0;
   endtask

   // Predict the next drain from the model and advance the model's slot pointer
   task automatic modelDrain(input logic [7:0] extra);
      expQueue.push_back(modelRing[modelCur] | extra);
      modelRing[modelCur] = 8'h00;
      modelCur = (modelCur + 1) % 16;
   endtask

   task automatic pulseTick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic applyTick();
      modelDrain(8'h00);
      pulseTick();
   endtask

   // Wait for all predicted vectors to be delivered, bounded by a cycle budget
   task automatic waitDrained(input int budget);
      int n;
      n = 0;
      while ((expQueue.size() != 0 || outValid) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) checkOutput("drain_timeout", 1, 0);
   endtask

   // Scoreboard monitor: compare on every delivered vector, sampled on the falling edge
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (rst && outValid && outReady) begin
            if (expQueue.size() == 0) begin
               checkOutput("unexpected_out_valid", 1, 0);
            end else begin
               exp = expQueue.pop_front();
               checkOutput("out_vec", outVec, exp);
            end
         end
      end
   end

   initial begin
      rst      = 1'b0;
      spkValid = 1'b0;
      spkAxon  = 3'd0;
      spkDelay = 4'd0;
      tick     = 1'b0;
      outReady = 1'b1;
      clearModel();
      #2;
      applyReset();

      // Delay-0 spike, one tick, one-cycle valid and latency check
      applyStimulus(3, 0);
      checkOutput("count_one", spikeCount, 1);
      modelDrain(8'h00);
      tick = 1'b1;
      step();
      tick = 1'b0;
      checkOutput("latency_not_yet", outValid, 0);
      step();
      checkOutput("latency_valid", outValid, 1);
      checkOutput("latency_vec", outVec, 8'h08);
      checkOutput("slot_advanced", curSlot, 1);
      step();
      checkOutput("valid_one_cycle", outValid, 0);
      waitDrained(20);

      // Delay 2 from slot 0 appears on the third drain
      applyReset();
      applyStimulus(1, 2);
      for (int i = 0; i < 3; i++) begin
         applyTick();
         waitDrained(20);
      end
      checkOutput("slot_after_three", curSlot, 3);

      // Wrap-around: slot 14 plus delay 5 lands in slot 3
      for (int i = 0; i < 11; i++) begin
         applyTick();
         waitDrained(20);
      end
      checkOutput("slot_at_14", curSlot, 14);
      applyStimulus(7, 5);
      for (int i = 0; i < 6; i++) begin
         applyTick();
         waitDrained(20);
      end
      checkOutput("slot_after_wrap", curSlot, 4);

      // Spike hitting the slot under drain, OR-merged with queued and duplicate spikes
      applyStimulus(2, 0);
      applyStimulus(2, 0);
      checkOutput("dup_count", spikeCount, modelCount);
      tick = 1'b1;
      step();
      tick = 1'b0;
      spkValid = 1'b1;
      spkAxon  = 3'd5;
      spkDelay = 4'd0;
      if (modelCount < 255) modelCount++;
      modelDrain(8'h20);
      step();
      spkValid = 1'b0;
      waitDrained(20);
      checkOutput("drain_spike_count", spikeCount, modelCount);

      // Stalled consumer: one pending tick kept, the next one dropped
      outReady = 1'b0;
      applyStimulus(0, 0);
      applyStimulus(6, 1);
      applyTick();
      step();
      checkOutput("stall_valid", outValid, 1);
      modelDrain(8'h00);
      pulseTick();
      checkOutput("pending_no_overrun", tickOverrun, 0);
      pulseTick();
      checkOutput("overrun_set", tickOverrun, 1);
      for (int i = 0; i < 3; i++) step();
      checkOutput("stall_held_vec", outVec, 8'h01);
      outReady = 1'b1;
      waitDrained(40);
      for (int i = 0; i < 10; i++) step();
      checkOutput("one_extra_drain", curSlot, modelCur);
      checkOutput("overrun_sticky", tickOverrun, 1);

      // 300 random spikes: counter saturates, then the whole ring is drained
      for (int i = 0; i < 300; i++) begin
         applyStimulus(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)));
      end
      checkOutput("count_saturated", spikeCount, 255);
      for (int i = 0; i < 16; i++) begin
         applyTick();
         waitDrained(20);
      end

      // Reset while presenting with queued slots discards everything
      for (int i = 0; i < 8; i++) applyStimulus(i, i + 1);
      outReady = 1'b0;
      applyTick();
      step();
      checkOutput("pre_rst_valid", outValid, 1);
      #2;
      applyReset();
      outReady = 1'b1;
      for (int i = 0; i < 6; i++) step();
      checkOutput("no_valid_without_tick", outValid, 0);
      for (int i = 0; i < 16; i++) begin
         applyTick();
         waitDrained(20);
      end
      checkOutput("post_rst_slot", curSlot, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
